fetch_hazard_ctrl: RTL and testbench
====================================

// Module: fetch_hazard_ctrl
// PURPOSE
//  Sequencer for the IF/ID pipeline latch and fetch PC. Combines branch-mispredict
//  resolution from EX, I-cache miss status and load-use detection in ID.
//  Produces the latch STALL/FLUSH controls, the ID/EX bubble and the PC redirect.
//  Keeps performance counters for stall and flush cycles.
// PARAMETERS
//  FLUSH_CYCLES  1    cycles IFID_FLUSH stays high after a mispredict (>=1)
//  MISS_TIMEOUT  255  MISS_WAIT cycles before MISS_ERR is set (8-bit counter)
//  CNT_W         32   width of perf counters
// PORTS
//  CLK             in   1      clock, posedge
//  RESET           in   1      asynchronous, active-low reset
//  EX_Br_Valid     in   1      a branch/jump is resolving in EX this cycle
//  EX_Br_Taken     in   1      actual outcome
//  EX_Pred_Taken   in   1      prediction carried with the instruction
//  EX_Pred_Addr    in   32     predicted target carried with the instruction
//  EX_Target       in   32     computed target
//  EX_PC_Plus4     in   32     fall-through address
//  EX_MemRead      in   1      instruction in EX is a load
//  EX_Rt           in   5      load destination register
//  ID_Rs / ID_Rt   in   5      source registers of the instruction in ID
//  ID_Uses_Rt      in   1      ID instruction reads Rt
//  IC_Miss         in   1      I-cache miss on the current fetch
//  IC_Ready        in   1      refill complete
//  IF_STALL        out  1      freeze PC / fetch
//  IFID_STALL      out  1      STALL to IF/ID latch
//  IFID_FLUSH      out  1      FLUSH to IF/ID latch (overrides STALL in the latch)
//  IDEX_BUBBLE     out  1      insert NOP into ID/EX
//  PC_Redirect     out  1      load PC from PC_Redirect_Addr
//  PC_Redirect_Addr out 32     corrected fetch address
//  IC_Abort        out  1      one-cycle pulse: cancel the outstanding refill
//  MISS_ERR        out  1      sticky; refill exceeded MISS_TIMEOUT
//  Stall_Cnt       out  CNT_W  cycles with IF_STALL=1
//  Flush_Cnt       out  CNT_W  cycles with IFID_FLUSH=1
// BEHAVIOUR
//  Reset (RESET=0, any time): state=RUN; all counters, MISS_ERR and the timeout
//   counter are 0. Control outputs then follow state RUN with the inputs.
//  Control outputs are combinational from state and current inputs. They act in
//   the same cycle, at the next CLK edge of the latch.
//  mispredict = EX_Br_Valid & ((EX_Br_Taken!=EX_Pred_Taken) |
//               (EX_Br_Taken & EX_Pred_Taken & EX_Pred_Addr!=EX_Target))
//  correct = EX_Br_Taken ? EX_Target : EX_PC_Plus4
//  load_use = EX_MemRead & EX_Rt!=0 & (EX_Rt==ID_Rs | (ID_Uses_Rt & EX_Rt==ID_Rt))
//  Priority within a cycle: mispredict > miss > load_use.
//  States RUN, MISS_WAIT, FLUSH_HOLD:
//  RUN, mispredict:
//   - PC_Redirect=1, PC_Redirect_Addr=correct, IFID_FLUSH=1, IDEX_BUBBLE=1.
//   - Go to FLUSH_HOLD if FLUSH_CYCLES>1 (hold counter=FLUSH_CYCLES-1), else stay RUN.
//  RUN, IC_Miss (no mispredict): IF_STALL=1, IFID_FLUSH=1; go to MISS_WAIT, timeout=0.
//  RUN, load_use only: IF_STALL=1, IFID_STALL=1, IDEX_BUBBLE=1 for exactly that cycle.
//  MISS_WAIT:
//   - IF_STALL=1, IFID_FLUSH=1; timeout increments, saturating.
//   - When timeout reaches MISS_TIMEOUT, set MISS_ERR.
//   - IC_Ready: outputs as RUN with IC_Miss=0 that cycle; go to RUN.
//   - Mispredict during MISS_WAIT: redirect as in RUN, plus IC_Abort=1.
//     Next state is FLUSH_HOLD or RUN as above. Mispredict beats IC_Ready.
//  FLUSH_HOLD:
//   - IFID_FLUSH=1, IF_STALL=0.
//   - Hold counter decrements; go to RUN when it reaches 0.
//   - A new mispredict restarts the hold and redirects again.
//   - IC_Miss here is ignored (wrong-path fetch); IC_Abort=1.
//  PC_Redirect is only ever high for one cycle per mispredict.
//  IDEX_BUBBLE never fires on a load_use that is masked by a miss or mispredict.
//  Counters wrap at 2^CNT_W.
// TESTING
//  1. Reset mid MISS_WAIT -> RUN next cycle, outputs 0, Stall_Cnt=0, MISS_ERR=0.
//  2. EX_MemRead=1, EX_Rt=5, ID_Rs=5 for 1 cycle -> IF_STALL=IFID_STALL=IDEX_BUBBLE=1
//     that cycle only. EX_Rt=0 gives no stall.
//  3. EX_Br_Valid, Taken=1, Pred=0, Target=0x400 -> PC_Redirect=1, addr 0x400,
//     IFID_FLUSH=1, Flush_Cnt+1. With FLUSH_CYCLES=3, FLUSH 3 cycles.
//  4. Pred_Taken=Taken=1, EX_Pred_Addr=0x100, EX_Target=0x104 -> redirect to 0x104.
//  5. IC_Miss then IC_Ready after 4 cycles -> IF_STALL 5 cycles, Stall_Cnt=5.
//     MISS_TIMEOUT=3 sets MISS_ERR.
//  6. Mispredict same cycle as IC_Ready in MISS_WAIT -> IC_Abort=1, PC_Redirect=1,
//     no load_use bubble.

Source files
------------

// File: rtl/fetch_hazard_ctrl.sv
// IF/ID latch and fetch-PC sequencer: mispredict redirect, I-cache miss wait,
// load-use stall, plus stall/flush performance counters.
module fetch_hazard_ctrl #(
    parameter int FLUSH_CYCLES = 1,
    parameter int MISS_TIMEOUT = 255,
    parameter int CNT_W        = 32
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             EX_Br_Valid,
    input  logic             EX_Br_Taken,
    input  logic             EX_Pred_Taken,
    input  logic [31:0]      EX_Pred_Addr,
    input  logic [31:0]      EX_Target,
    input  logic [31:0]      EX_PC_Plus4,
    input  logic             EX_MemRead,
    input  logic [4:0]       EX_Rt,
    input  logic [4:0]       ID_Rs,
    input  logic [4:0]       ID_Rt,
    input  logic             ID_Uses_Rt,
    input  logic             IC_Miss,
    input  logic             IC_Ready,
    output logic             IF_STALL,
    output logic             IFID_STALL,
    output logic             IFID_FLUSH,
    output logic             IDEX_BUBBLE,
    output logic             PC_Redirect,
    output logic [31:0]      PC_Redirect_Addr,
    output logic             IC_Abort,
    output logic             MISS_ERR,
    output logic [CNT_W-1:0] Stall_Cnt,
    output logic [CNT_W-1:0] Flush_Cnt
);

    localparam int HW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [HW-1:0] HOLD_INIT = HW'(FLUSH_CYCLES - 1);
    localparam logic [7:0] TMO_LIM = 8'(MISS_TIMEOUT);
    localparam bit HOLD_EN = (FLUSH_CYCLES > 1);

    typedef enum logic [1:0] {RUN, MISS_WAIT, FLUSH_HOLD} state_e;

    state_e           state_q, state_d;
    logic [HW-1:0]    hold_q, hold_d;
    logic [7:0]       tmo_q, tmo_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

    logic       mispredict;
    logic       load_use;
    logic [7:0] tmo_inc;

    assign mispredict = EX_Br_Valid &
        ((EX_Br_Taken != EX_Pred_Taken) |
         (EX_Br_Taken & EX_Pred_Taken & (EX_Pred_Addr != EX_Target)));

    assign load_use = EX_MemRead & (EX_Rt != 5'd0) &
        ((EX_Rt == ID_Rs) | (ID_Uses_Rt & (EX_Rt == ID_Rt)));

    assign tmo_inc = (tmo_q == 8'hFF) ? tmo_q : tmo_q + 8'd1;

    assign PC_Redirect_Addr = EX_Br_Taken ? EX_Target : EX_PC_Plus4;
    assign MISS_ERR  = err_q;
    assign Stall_Cnt = stall_cnt_q;
    assign Flush_Cnt = flush_cnt_q;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q     <= RUN;
            hold_q      <= '0;
            tmo_q       <= '0;
            err_q       <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            tmo_q       <= tmo_d;
            err_q       <= err_d;
            stall_cnt_q <= stall_cnt_q + CNT_W'(IF_STALL);
            flush_cnt_q <= flush_cnt_q + CNT_W'(IFID_FLUSH);
        end
    end

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        tmo_d   = tmo_q;
        err_d   = err_q;
        unique case (state_q)
            RUN: begin
                if (mispredict) begin
                    state_d = HOLD_EN ? FLUSH_HOLD : RUN;
                    hold_d  = HOLD_INIT;
                end else if (IC_Miss) begin
                    state_d = MISS_WAIT;
                    tmo_d   = '0;
                end
            end
            MISS_WAIT: begin
                tmo_d = tmo_inc;
                if (tmo_inc >= TMO_LIM)
                    err_d = 1'b1;
                if (mispredict) begin
                    state_d = HOLD_EN ? FLUSH_HOLD : RUN;
                    hold_d  = HOLD_INIT;
                end else if (IC_Ready) begin
                    state_d = RUN;
                end
            end
            FLUSH_HOLD: begin
                if (mispredict) begin
                    hold_d = HOLD_INIT;
                end else begin
                    hold_d = hold_q - HW'(1);
                    if (hold_q == HW'(1))
                        state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    // A pending miss or redirect masks load-use: the ID slot is being flushed.
    always_comb begin
        IF_STALL    = 1'b0;
        IFID_STALL  = 1'b0;
        IFID_FLUSH  = 1'b0;
        IDEX_BUBBLE = 1'b0;
        PC_Redirect = 1'b0;
        IC_Abort    = 1'b0;
        unique case (state_q)
            RUN: begin
                if (mispredict) begin
                    PC_Redirect = 1'b1;
                    IFID_FLUSH  = 1'b1;
                    IDEX_BUBBLE = 1'b1;
                end else if (IC_Miss) begin
                    IF_STALL   = 1'b1;
                    IFID_FLUSH = 1'b1;
                end else if (load_use) begin
                    IF_STALL    = 1'b1;
                    IFID_STALL  = 1'b1;
                    IDEX_BUBBLE = 1'b1;
                end
            end
            MISS_WAIT: begin
                if (mispredict) begin
                    PC_Redirect = 1'b1;
                    IFID_FLUSH  = 1'b1;
                    IDEX_BUBBLE = 1'b1;
                    IC_Abort    = 1'b1;
                end else if (IC_Ready) begin
                    if (load_use) begin
                        IF_STALL    = 1'b1;
                        IFID_STALL  = 1'b1;
                        IDEX_BUBBLE = 1'b1;
                    end
                end else begin
                    IF_STALL   = 1'b1;
                    IFID_FLUSH = 1'b1;
                end
            end
            FLUSH_HOLD: begin
                IFID_FLUSH = 1'b1;
                IC_Abort   = IC_Miss;
                if (mispredict) begin
                    PC_Redirect = 1'b1;
                    IDEX_BUBBLE = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_fetch_hazard_ctrl.sv
// Randomized and directed bench for fetch_hazard_ctrl against a
// cycle-level behavioural model of the hazard rules.
module tb_fetch_hazard_ctrl;

    localparam int FC = 3;
    localparam int MT = 3;
    localparam int CW = 32;

    logic          CLK = 1'b0;
    logic          RESET = 1'b0;
    logic          EX_Br_Valid, EX_Br_Taken, EX_Pred_Taken;
    logic [31:0]   EX_Pred_Addr, EX_Target, EX_PC_Plus4;
    logic          EX_MemRead;
    logic [4:0]    EX_Rt, ID_Rs, ID_Rt;
    logic          ID_Uses_Rt, IC_Miss, IC_Ready;
    logic          IF_STALL, IFID_STALL, IFID_FLUSH, IDEX_BUBBLE;
    logic          PC_Redirect, IC_Abort, MISS_ERR;
    logic [31:0]   PC_Redirect_Addr;
    logic [CW-1:0] Stall_Cnt, Flush_Cnt;

    fetch_hazard_ctrl #(
        .FLUSH_CYCLES(FC), .MISS_TIMEOUT(MT), .CNT_W(CW)
    ) dut (
        .CLK(CLK), .RESET(RESET),
        .EX_Br_Valid(EX_Br_Valid), .EX_Br_Taken(EX_Br_Taken),
        .EX_Pred_Taken(EX_Pred_Taken), .EX_Pred_Addr(EX_Pred_Addr),
        .EX_Target(EX_Target), .EX_PC_Plus4(EX_PC_Plus4),
        .EX_MemRead(EX_MemRead), .EX_Rt(EX_Rt),
        .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_Uses_Rt(ID_Uses_Rt),
        .IC_Miss(IC_Miss), .IC_Ready(IC_Ready),
        .IF_STALL(IF_STALL), .IFID_STALL(IFID_STALL),
        .IFID_FLUSH(IFID_FLUSH), .IDEX_BUBBLE(IDEX_BUBBLE),
        .PC_Redirect(PC_Redirect), .PC_Redirect_Addr(PC_Redirect_Addr),
        .IC_Abort(IC_Abort), .MISS_ERR(MISS_ERR),
        .Stall_Cnt(Stall_Cnt), .Flush_Cnt(Flush_Cnt)
    );

    always #5 CLK = ~CLK;

    wire [6:0] obs = {IF_STALL, IFID_STALL, IFID_FLUSH, IDEX_BUBBLE,
                      PC_Redirect, IC_Abort, MISS_ERR};

    int checks = 0;
    int failures = 0;

    // model state: pending miss, remaining hold cycles, miss age
    bit          m_miss, n_miss;
    int          m_hold, n_hold;
    int          m_age, n_age;
    bit          m_err, n_err;
    logic [31:0] m_sc, m_fc;
    bit          e_stall, e_ifs, e_fl, e_bub, e_red, e_abt;
    logic [31:0] e_addr;
    logic [6:0]  expv;

    task automatic model_reset();
        m_miss = 0; m_hold = 0; m_age = 0; m_err = 0;
        m_sc = 0; m_fc = 0;
    endtask

    task automatic clr();
        EX_Br_Valid = 0; EX_Br_Taken = 0; EX_Pred_Taken = 0;
        EX_Pred_Addr = 0; EX_Target = 0; EX_PC_Plus4 = 0;
        EX_MemRead = 0; EX_Rt = 0; ID_Rs = 0; ID_Rt = 0;
        ID_Uses_Rt = 0; IC_Miss = 0; IC_Ready = 0;
    endtask

    task automatic eval_model();
        bit mp, lu;
        mp = EX_Br_Valid && ((EX_Br_Taken != EX_Pred_Taken) ||
             (EX_Br_Taken && EX_Pred_Taken && EX_Pred_Addr != EX_Target));
        lu = EX_MemRead && EX_Rt != 0 &&
             (EX_Rt == ID_Rs || (ID_Uses_Rt && EX_Rt == ID_Rt));
        e_stall = 0; e_ifs = 0; e_fl = 0; e_bub = 0; e_red = 0; e_abt = 0;
        e_addr = EX_Br_Taken ? EX_Target : EX_PC_Plus4;
        n_miss = m_miss; n_hold = m_hold; n_age = m_age; n_err = m_err;
        if (m_hold > 0) begin
            e_fl = 1; e_abt = IC_Miss;
            if (mp) begin e_red = 1; e_bub = 1; n_hold = FC - 1; end
            else n_hold = m_hold - 1;
        end else if (m_miss) begin
            n_age = (m_age + 1 > 255) ? 255 : m_age + 1;
            if (n_age >= MT) n_err = 1;
            if (mp) begin
                e_red = 1; e_fl = 1; e_bub = 1; e_abt = 1;
                n_miss = 0; n_hold = FC - 1;
            end else if (IC_Ready) begin
                n_miss = 0;
                if (lu) begin e_stall = 1; e_ifs = 1; e_bub = 1; end
            end else begin
                e_stall = 1; e_fl = 1;
            end
        end else begin
            if (mp) begin
                e_red = 1; e_fl = 1; e_bub = 1; n_hold = FC - 1;
            end else if (IC_Miss) begin
                e_stall = 1; e_fl = 1; n_miss = 1; n_age = 0;
            end else if (lu) begin
                e_stall = 1; e_ifs = 1; e_bub = 1;
            end
        end
        expv = {e_stall, e_ifs, e_fl, e_bub, e_red, e_abt, m_err};
    endtask

    task automatic adv();
        @(posedge CLK);
        m_miss = n_miss; m_hold = n_hold; m_age = n_age; m_err = n_err;
        m_sc = m_sc + 32'(e_stall);
        m_fc = m_fc + 32'(e_fl);
        @(negedge CLK);
    endtask

    task automatic test_reset();
        clr();
        model_reset();
        repeat (2) @(negedge CLK);
        RESET = 1;
        #1;
        eval_model();
        checks++;
        if (obs !== 7'b0 || Stall_Cnt !== 0 || Flush_Cnt !== 0) begin
            failures++;
            $display("FAIL reset_state obs=%b sc=%0d fc=%0d req=0", obs, Stall_Cnt, Flush_Cnt);
        end
        adv();
        IC_Miss = 1;
        for (int i = 0; i < 3; i++) begin
            #1; eval_model();
            checks++;
            if (obs !== expv) begin
                failures++;
                $display("FAIL reset_pre_miss obs=%b req=%b", obs, expv);
            end
            adv();
            IC_Miss = 0;
        end
        RESET = 0;
        model_reset();
        #1;
        checks++;
        if (obs !== 7'b0 || Stall_Cnt !== 0 || MISS_ERR !== 0) begin
            failures++;
            $display("FAIL reset_mid_miss obs=%b sc=%0d req obs=0 sc=0", obs, Stall_Cnt);
        end
        @(posedge CLK);
        @(negedge CLK);
        RESET = 1;
        #1; eval_model();
        checks++;
        if (obs !== 7'b0 || expv !== 7'b0) begin
            failures++;
            $display("FAIL reset_run_after obs=%b req=0", obs);
        end
        adv();
    endtask

    task automatic test_load_use();
        clr();
        EX_MemRead = 1; EX_Rt = 5; ID_Rs = 5;
        #1; eval_model();
        checks++;
        if (obs !== 7'b1101000 || obs !== expv) begin
            failures++;
            $display("FAIL load_use_rs obs=%b req=1101000", obs);
        end
        adv();
        clr();
        #1; eval_model();
        checks++;
        if (obs !== 7'b0) begin
            failures++;
            $display("FAIL load_use_release obs=%b req=0", obs);
        end
        adv();
        EX_MemRead = 1; EX_Rt = 0; ID_Rs = 0; ID_Rt = 0; ID_Uses_Rt = 1;
        #1; eval_model();
        checks++;
        if (obs !== 7'b0) begin
            failures++;
            $display("FAIL load_use_r0 obs=%b req=0", obs);
        end
        adv();
        EX_Rt = 7; ID_Rs = 1; ID_Rt = 7; ID_Uses_Rt = 1;
        #1; eval_model();
        checks++;
        if (obs !== 7'b1101000) begin
            failures++;
            $display("FAIL load_use_rt obs=%b req=1101000", obs);
        end
        adv();
        ID_Uses_Rt = 0;
        #1; eval_model();
        checks++;
        if (obs !== 7'b0) begin
            failures++;
            $display("FAIL load_use_rt_unused obs=%b req=0", obs);
        end
        adv();
        clr();
    endtask

    task automatic test_mispredict();
        logic [31:0] fc0;
        clr();
        fc0 = m_fc;
        EX_Br_Valid = 1; EX_Br_Taken = 1; EX_Pred_Taken = 0;
        EX_Target = 32'h400; EX_PC_Plus4 = 32'h204;
        #1; eval_model();
        checks++;
        if (obs !== 7'b0011100 || PC_Redirect_Addr !== 32'h400) begin
            failures++;
            $display("FAIL mispredict_redirect obs=%b addr=%h req=0011100 400", obs, PC_Redirect_Addr);
        end
        adv();
        clr();
        for (int i = 0; i < 2; i++) begin
            #1; eval_model();
            checks++;
            if (obs !== 7'b0010000 || PC_Redirect !== 1'b0) begin
                failures++;
                $display("FAIL mispredict_hold%0d obs=%b req=0010000", i, obs);
            end
            adv();
        end
        #1; eval_model();
        checks++;
        if (obs !== 7'b0 || Flush_Cnt !== fc0 + 3) begin
            failures++;
            $display("FAIL mispredict_flush_cnt obs=%b fc=%0d req fc=%0d", obs, Flush_Cnt, fc0 + 3);
        end
        adv();
    endtask

    task automatic test_pred_addr();
        clr();
        EX_Br_Valid = 1; EX_Br_Taken = 1; EX_Pred_Taken = 1;
        EX_Pred_Addr = 32'h100; EX_Target = 32'h104; EX_PC_Plus4 = 32'h80;
        #1; eval_model();
        checks++;
        if (PC_Redirect !== 1'b1 || PC_Redirect_Addr !== 32'h104) begin
            failures++;
            $display("FAIL pred_addr redir=%b addr=%h req=1 104", PC_Redirect, PC_Redirect_Addr);
        end
        adv();
        clr();
        repeat (2) begin #1; eval_model(); adv(); end
        EX_Br_Valid = 1; EX_Br_Taken = 1; EX_Pred_Taken = 1;
        EX_Pred_Addr = 32'h300; EX_Target = 32'h300;
        #1; eval_model();
        checks++;
        if (obs !== expv || PC_Redirect !== 1'b0) begin
            failures++;
            $display("FAIL pred_correct obs=%b req=%b", obs, expv);
        end
        adv();
        EX_Br_Taken = 0; EX_Pred_Taken = 1; EX_PC_Plus4 = 32'h504;
        #1; eval_model();
        checks++;
        if (PC_Redirect !== 1'b1 || PC_Redirect_Addr !== 32'h504) begin
            failures++;
            $display("FAIL pred_not_taken redir=%b addr=%h req=1 504", PC_Redirect, PC_Redirect_Addr);
        end
        adv();
        clr();
        repeat (2) begin #1; eval_model(); adv(); end
    endtask

    task automatic test_miss();
        logic [31:0] sc0;
        clr();
        sc0 = m_sc;
        IC_Miss = 1;
        for (int i = 0; i < 6; i++) begin
            IC_Ready = (i == 5);
            #1; eval_model();
            checks++;
            if (obs !== expv) begin
                failures++;
                $display("FAIL miss_cycle%0d obs=%b req=%b", i, obs, expv);
            end
            adv();
            IC_Miss = 0;
        end
        clr();
        #1; eval_model();
        checks++;
        if (Stall_Cnt !== sc0 + 5 || MISS_ERR !== 1'b1 || obs !== 7'b0000001) begin
            failures++;
            $display("FAIL miss_stall_cnt sc=%0d err=%b req sc=%0d err=1", Stall_Cnt, MISS_ERR, sc0 + 5);
        end
        adv();
    endtask

    task automatic test_abort();
        clr();
        IC_Miss = 1;
        #1; eval_model(); adv();
        IC_Miss = 0;
        #1; eval_model(); adv();
        IC_Ready = 1; EX_Br_Valid = 1; EX_Br_Taken = 0; EX_Pred_Taken = 1;
        EX_PC_Plus4 = 32'h88; EX_MemRead = 1; EX_Rt = 3; ID_Rs = 3;
        #1; eval_model();
        checks++;
        if (obs !== 7'b0011111 || PC_Redirect_Addr !== 32'h88) begin
            failures++;
            $display("FAIL abort_on_ready obs=%b addr=%h req=0011111 88", obs, PC_Redirect_Addr);
        end
        adv();
        clr();
        IC_Miss = 1;
        #1; eval_model();
        checks++;
        if (IC_Abort !== 1'b1 || IF_STALL !== 1'b0 || obs !== expv) begin
            failures++;
            $display("FAIL abort_in_hold obs=%b req=%b", obs, expv);
        end
        adv();
        clr();
        repeat (2) begin #1; eval_model(); adv(); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            EX_Br_Valid = ($urandom_range(0, 9) < 3);
            EX_Br_Taken = $urandom_range(0, 1) == 1;
            EX_Pred_Taken = $urandom_range(0, 1) == 1;
            EX_Target = $urandom;
            EX_Pred_Addr = ($urandom_range(0, 1) == 1) ? EX_Target : $urandom;
            EX_PC_Plus4 = $urandom;
            EX_MemRead = ($urandom_range(0, 9) < 4);
            EX_Rt = 5'($urandom_range(0, 3));
            ID_Rs = 5'($urandom_range(0, 3));
            ID_Rt = 5'($urandom_range(0, 3));
            ID_Uses_Rt = $urandom_range(0, 1) == 1;
            IC_Miss = ($urandom_range(0, 99) < 15);
            IC_Ready = ($urandom_range(0, 9) < 3);
            #1; eval_model();
            checks++;
            if (obs !== expv || Stall_Cnt !== m_sc || Flush_Cnt !== m_fc ||
                (e_red && PC_Redirect_Addr !== e_addr)) begin
                failures++;
                $display("FAIL random%0d obs=%b req=%b sc=%0d/%0d fc=%0d/%0d addr=%h/%h",
                         i, obs, expv, Stall_Cnt, m_sc, Flush_Cnt, m_fc,
                         PC_Redirect_Addr, e_addr);
            end
            adv();
        end
        clr();
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_mispredict();
        test_pred_addr();
        test_miss();
        test_abort();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
